// File: rtl/hazard_stall_ctrl_if.sv
// Interface between the hazard/stall controller and the pipeline registers it sequences.
// The master drives the ID/EX hazard inputs; the slave is the controller.
interface hazard_stall_ctrl_if;
    logic [4:0]  ID_RSAddr;
    logic [4:0]  ID_RTAddr;
    logic        ID_UsesRT;
    logic        ID_MultiCycle;
    logic [1:0]  EX_Mem2RegSEL;
    logic        EX_RegWriteEN;
    logic [4:0]  EX_RTAddr;
    logic        BranchTaken;
    logic        PCWriteEN;
    logic        IFIDWriteEN;
    logic        IFIDFlush;
    logic        IDEXBubble;
    logic        EXBusy;
    logic [15:0] StallCount;

    modport master (
        output ID_RSAddr, ID_RTAddr, ID_UsesRT, ID_MultiCycle,
        output EX_Mem2RegSEL, EX_RegWriteEN, EX_RTAddr, BranchTaken,
        input  PCWriteEN, IFIDWriteEN, IFIDFlush, IDEXBubble, EXBusy, StallCount
    );

    modport slave (
        input  ID_RSAddr, ID_RTAddr, ID_UsesRT, ID_MultiCycle,
        input  EX_Mem2RegSEL, EX_RegWriteEN, EX_RTAddr, BranchTaken,
        output PCWriteEN, IFIDWriteEN, IFIDFlush, IDEXBubble, EXBusy, StallCount
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Front-end sequencing for a 5-stage pipeline: load-use stalls, branch flushes,
// multi-cycle EX occupancy, plus a saturating stalled-cycle counter.
module hazard_stall_ctrl #(
    parameter int         MULTI_LATENCY = 4,
    parameter logic [1:0] LOAD_SEL      = 2'b01
) (
    input  logic               CLOCK,
    input  logic               RESET,
    hazard_stall_ctrl_if.slave hz
);

    typedef enum logic {RUN, MULTI} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MULTI_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] stall_cnt;

    logic load_use;
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic ex_busy;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign load_use = (hz.EX_Mem2RegSEL == LOAD_SEL) && hz.EX_RegWriteEN &&
                      (hz.EX_RTAddr != 5'd0) &&
                      ((hz.EX_RTAddr == hz.ID_RSAddr) ||
                       (hz.ID_UsesRT && (hz.EX_RTAddr == hz.ID_RTAddr)));

    // Outputs follow state and inputs directly; reset forces the front end into a flushed hold.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_busy     = 1'b0;
        if (RESET) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state == MULTI) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            ex_busy     = 1'b1;
        end else if (hz.BranchTaken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= RUN;
            cnt       <= 4'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (!pc_we)
                stall_cnt <= sat_inc(stall_cnt);
            case (state)
                RUN: begin
                    // A multi-cycle op only issues when nothing higher-priority holds it back.
                    if (!hz.BranchTaken && !load_use && hz.ID_MultiCycle) begin
                        state <= MULTI;
                        cnt   <= CNT_INIT;
                    end
                end
                MULTI: begin
                    if (cnt == 4'd1) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign hz.PCWriteEN   = pc_we;
    assign hz.IFIDWriteEN = ifid_we;
    assign hz.IFIDFlush   = ifid_flush;
    assign hz.IDEXBubble  = idex_bubble;
    assign hz.EXBusy      = ex_busy;
    assign hz.StallCount  = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, multi-cycle, branch priority,
// asynchronous reset mid-op and stall counter saturation.
module tb_hazard_stall_ctrl;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hazard_stall_ctrl_if hz ();

    hazard_stall_ctrl #(.MULTI_LATENCY(4), .LOAD_SEL(2'b01)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .hz    (hz.slave)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clear_inputs();
        hz.ID_RSAddr     = 5'd0;
        hz.ID_RTAddr     = 5'd0;
        hz.ID_UsesRT     = 1'b0;
        hz.ID_MultiCycle = 1'b0;
        hz.EX_Mem2RegSEL = 2'b00;
        hz.EX_RegWriteEN = 1'b0;
        hz.EX_RTAddr     = 5'd0;
        hz.BranchTaken   = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rt);
        hz.EX_Mem2RegSEL = 2'b01;
        hz.EX_RegWriteEN = 1'b1;
        hz.EX_RTAddr     = rt;
    endtask

    task automatic clear_ex();
        hz.EX_Mem2RegSEL = 2'b00;
        hz.EX_RegWriteEN = 1'b0;
        hz.EX_RTAddr     = 5'd0;
    endtask

    task automatic check_outs(input string tag, input logic pc, input logic ifid,
                              input logic fl, input logic bub, input logic busy);
        check({tag, "_pc"},    32'(hz.PCWriteEN),   32'(pc));
        check({tag, "_ifid"},  32'(hz.IFIDWriteEN), 32'(ifid));
        check({tag, "_flush"}, 32'(hz.IFIDFlush),   32'(fl));
        check({tag, "_bub"},   32'(hz.IDEXBubble),  32'(bub));
        check({tag, "_busy"},  32'(hz.EXBusy),      32'(busy));
    endtask

    initial begin
        clear_inputs();
        #1;
        // reset values
        check_outs("rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_cnt", 32'(hz.StallCount), 32'd0);
        step();
        step();
        RESET = 1'b0;
        #1;
        check_outs("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // load-use on RS: one stall cycle
        set_load(5'd5);
        hz.ID_RSAddr = 5'd5;
        #1;
        check_outs("lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        clear_ex();
        #1;
        check_outs("lu_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_cnt", 32'(hz.StallCount), 32'd1);

        // load to r0 never stalls
        set_load(5'd0);
        hz.ID_RSAddr = 5'd0;
        #1;
        check("r0_pc", 32'(hz.PCWriteEN), 32'd1);
        // RT match ignored unless the instruction reads RT
        set_load(5'd5);
        hz.ID_RSAddr = 5'd3;
        hz.ID_RTAddr = 5'd5;
        hz.ID_UsesRT = 1'b0;
        #1;
        check("rt_unused_pc", 32'(hz.PCWriteEN), 32'd1);
        hz.ID_UsesRT = 1'b1;
        #1;
        check("rt_used_pc", 32'(hz.PCWriteEN), 32'd0);
        // non-load producer does not stall
        hz.EX_Mem2RegSEL = 2'b00;
        #1;
        check("alu_pc", 32'(hz.PCWriteEN), 32'd1);
        clear_inputs();
        step();
        check("no_stall_cnt", 32'(hz.StallCount), 32'd1);

        // multi-cycle op: issue, then 3 busy cycles
        hz.ID_MultiCycle = 1'b1;
        #1;
        check_outs("mc_issue", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        hz.ID_MultiCycle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hz.BranchTaken = (i == 1);
            set_load(5'd7);
            hz.ID_RSAddr = 5'd7;
            #1;
            check_outs($sformatf("mc_busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            step();
            clear_inputs();
        end
        #1;
        check_outs("mc_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mc_cnt", 32'(hz.StallCount), 32'd4);

        // branch outranks load-use and multi-cycle issue
        set_load(5'd9);
        hz.ID_RSAddr     = 5'd9;
        hz.ID_MultiCycle = 1'b1;
        hz.BranchTaken   = 1'b1;
        #1;
        check_outs("br", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        clear_inputs();
        #1;
        check_outs("br_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("br_cnt", 32'(hz.StallCount), 32'd4);

        // multi-cycle op behind a load-use: stall first, then issue
        set_load(5'd4);
        hz.ID_RSAddr     = 5'd4;
        hz.ID_MultiCycle = 1'b1;
        #1;
        check_outs("lumc_stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        clear_ex();
        #1;
        check_outs("lumc_issue", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_inputs();
        #1;
        check("lumc_busy1", 32'(hz.EXBusy), 32'd1);
        step();
        check("lumc_busy2", 32'(hz.EXBusy), 32'd1);
        check("lumc_cnt", 32'(hz.StallCount), 32'd6);

        // asynchronous reset in the second busy cycle
        #1;
        RESET = 1'b1;
        #1;
        check_outs("arst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("arst_cnt", 32'(hz.StallCount), 32'd0);
        RESET = 1'b0;
        #1;
        check_outs("arst_rel", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("arst_rel_cnt", 32'(hz.StallCount), 32'd0);
        check("arst_rel_busy", 32'(hz.EXBusy), 32'd0);

        // hold a load-use hazard until the counter saturates
        set_load(5'd12);
        hz.ID_RSAddr = 5'd12;
        for (int i = 0; i < 65534; i++) step();
        check("sat_fffe", 32'(hz.StallCount), 32'h0000FFFE);
        step();
        check("sat_ffff", 32'(hz.StallCount), 32'h0000FFFF);
        for (int i = 0; i < 10; i++) step();
        check("sat_hold", 32'(hz.StallCount), 32'h0000FFFF);
        check("sat_pc", 32'(hz.PCWriteEN), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
